instr_fetch_unit: RTL and testbench

Instruction fetch and issue front end for the 8-bit processor. Holds the program counter and reads instruction bytes from a synchronous instruction memory into a small prefetch FIFO. Assembles single-byte and two-byte (opcode + imm8) instructions, then presents them to the control unit over a valid/ready handshake. It is the producer end of the control unit's `inst` input.

---
 rtl/instr_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, prefetch byte FIFO and a
// one/two-byte instruction assembler feeding the control unit.
module instr_fetch_unit #(
  parameter int PC_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rvalid,
  input  logic [7:0]          imem_rdata,
  input  logic                redirect_en,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                halt,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [7:0]          inst,
  output logic [7:0]          imm,
  output logic [PC_WIDTH-1:0] inst_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_OP  = 1'b0;
  localparam logic [0:0] ST_IMM = 1'b1;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic                inflight;
  logic [PC_WIDTH-1:0] inflight_addr;

  logic [7:0]          fifo_data [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic [AW+1:0]       occupancy;

  logic [0:0]          state;
  logic [7:0]          hold_op;
  logic [PC_WIDTH-1:0] hold_pc;

  logic [7:0]          head_data;
  logic [PC_WIDTH-1:0] head_pc;
  logic                head_two;
  logic                fifo_empty;
  logic                slot_free;
  logic                push;
  logic                pop;
  logic                load;

  function automatic logic is_two_byte(input logic [7:0] op);
    logic two;
    unique case (op[7:4])
      4'h2, 4'h9, 4'hB, 4'hC,
      4'hD, 4'hE, 4'hF: two = 1'b1;
      default:          two = 1'b0;
    endcase
    return two;
  endfunction

  // Bytes already owned: stored in the FIFO plus one on its way back.
  always_comb begin
    occupancy = {1'b0, count}
              + {{(AW + 1){1'b0}}, inflight};
  end

  assign imem_req  = !reset && !halt && !redirect_en
                  && (occupancy < (AW + 2)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;

  assign head_data  = fifo_data[rd_ptr];
  assign head_pc    = fifo_pc[rd_ptr];
  assign head_two   = is_two_byte(head_data);
  assign fifo_empty = (count == '0);
  assign slot_free  = !inst_valid || inst_ready;
  assign pop        = !fifo_empty && slot_free;
  assign load       = pop && (state == ST_IMM || !head_two);

  // A response arriving in the redirect cycle is discarded by the
  // flush below; no request leaves in that cycle, so nothing stale
  // can arrive afterwards either.
  assign push = imem_rvalid && inflight;

  // Fetch pointer and record of the request issued last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc      <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else if (redirect_en) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_addr <= fetch_pc;
        fetch_pc      <= fetch_pc + PC_WIDTH'(1);
      end
    end
  end

  // FIFO storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= inflight_addr;
    end
  end

  // FIFO pointers and occupancy, emptied on reset or redirect.
  always_ff @(posedge clk) begin
    if (reset || redirect_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Assembler state: park a two-byte opcode until its immediate.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_OP;
      hold_op <= '0;
      hold_pc <= '0;
    end else if (redirect_en) begin
      state <= ST_OP;
    end else if (pop) begin
      unique case (state)
        ST_IMM: state <= ST_OP;
        default: begin
          if (head_two) begin
            state   <= ST_IMM;
            hold_op <= head_data;
            hold_pc <= head_pc;
          end
        end
      endcase
    end
  end

  // Output register: holds until accepted, reloads on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      imm        <= '0;
      inst_pc    <= '0;
    end else if (redirect_en) begin
      inst_valid <= 1'b0;
    end else if (load) begin
      inst_valid <= 1'b1;
      if (state == ST_IMM) begin
        inst    <= hold_op;
        imm     <= head_data;
        inst_pc <= hold_pc;
      end else begin
        inst    <= head_data;
        imm     <= '0;
        inst_pc <= head_pc;
      end
    end else if (inst_ready) begin
      inst_valid <= 1'b0;
    end
  end

  // The credit rule must keep every push within capacity.
  always_ff @(posedge clk) begin
    if (!reset && push && !pop) begin
      assert (count < (AW + 1)'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random stimulus checked against a
// queue-based model of the fetch front end and the program image.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_rvalid = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       redirect_en = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       halt = 1'b0;
  logic       inst_valid;
  logic       inst_ready = 1'b0;
  logic [7:0] inst;
  logic [7:0] imm;
  logic [7:0] inst_pc;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .imm         (imm),
    .inst_pc     (inst_pc)
  );

  typedef struct {
    logic [7:0] d;
    logic [7:0] pc;
  } fbyte_t;

  typedef struct {
    logic [7:0] op;
    logic [7:0] im;
    logic [7:0] pc;
    int         cyc;
  } issue_t;

  logic [7:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int first_valid = -1;
  bit armed = 1'b0;

  fbyte_t     m_q[$];
  bit         m_infl = 1'b0;
  logic [7:0] m_infl_addr = 8'h00;
  logic [7:0] m_fpc = 8'h00;
  bit         m_hold = 1'b0;
  logic [7:0] m_hold_op = 8'h00;
  logic [7:0] m_hold_pc = 8'h00;
  bit         m_v = 1'b0;
  logic [7:0] m_inst = 8'h00;
  logic [7:0] m_imm = 8'h00;
  logic [7:0] m_pc = 8'h00;
  issue_t     log_q[$];

  bit         pend = 1'b0;
  logic [7:0] pend_addr = 8'h00;
  logic [7:0] sb_next = 8'h00;

  function automatic bit two_byte(input logic [7:0] b);
    return b[7:4] inside {4'h2, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc_n);
    end
  endtask

  task automatic chk_issue(input string name, input int idx,
                           input logic [7:0] op, input logic [7:0] im,
                           input logic [7:0] pc);
    if (idx >= log_q.size()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d issues, expected entry %0d",
               name, log_q.size(), idx);
    end else begin
      chk({name, "_op"}, log_q[idx].op, op);
      chk({name, "_imm"}, log_q[idx].im, im);
      chk({name, "_pc"}, log_q[idx].pc, pc);
    end
  endtask

  // One clock cycle: drive, compare, then advance the model over the edge.
  task automatic cyc(input bit rst, input bit hlt, input bit rdr,
                     input logic [7:0] rpc, input bit rdy);
    bit         exp_req;
    fbyte_t     b;
    issue_t     e;
    logic [7:0] nxt;
    @(negedge clk);
    reset       = rst;
    halt        = hlt;
    redirect_en = rdr;
    redirect_pc = rpc;
    inst_ready  = rdy;
    imem_rvalid = pend;
    imem_rdata  = pend ? mem[pend_addr] : 8'h00;
    #1;
    exp_req = !rst && !hlt && !rdr && (m_q.size() + int'(m_infl) < 4);
    if (armed) begin
      chk("imem_req", imem_req, exp_req);
      chk("imem_addr", imem_addr, m_fpc);
      chk("inst_valid", inst_valid, m_v);
      if (m_v) begin
        chk("inst", inst, m_inst);
        chk("imm", imm, m_imm);
        chk("inst_pc", inst_pc, m_pc);
      end
      if (inst_valid === 1'b1 && rdy && !rst && !rdr) begin
        nxt = inst_pc + 8'd1;
        chk("stream_pc", inst_pc, sb_next);
        chk("stream_op", inst, mem[inst_pc]);
        chk("stream_imm", imm, two_byte(inst) ? mem[nxt] : 8'h00);
        sb_next = inst_pc + (two_byte(inst) ? 8'd2 : 8'd1);
      end
    end
    if (inst_valid === 1'b1 && first_valid < 0) first_valid = cyc_n;
    if (rst) sb_next = 8'h00;
    else if (rdr) sb_next = rpc;
    pend      = imem_req;
    pend_addr = imem_addr;

    if (rst) begin
      m_q.delete();
      m_infl = 0; m_infl_addr = 0; m_fpc = 0;
      m_hold = 0; m_hold_op = 0; m_hold_pc = 0;
      m_v = 0; m_inst = 0; m_imm = 0; m_pc = 0;
      armed = 1'b1;
    end else if (rdr) begin
      m_q.delete();
      m_infl = 0; m_fpc = rpc; m_hold = 0; m_v = 0;
    end else begin
      bit free;
      free = !m_v || rdy;
      if (m_v && rdy) begin
        e.op = m_inst; e.im = m_imm; e.pc = m_pc; e.cyc = cyc_n;
        log_q.push_back(e);
        m_v = 0;
      end
      if (free && m_q.size() > 0) begin
        b = m_q.pop_front();
        if (m_hold) begin
          m_inst = m_hold_op; m_imm = b.d; m_pc = m_hold_pc;
          m_v = 1; m_hold = 0;
        end else if (two_byte(b.d)) begin
          m_hold = 1; m_hold_op = b.d; m_hold_pc = b.pc;
        end else begin
          m_inst = b.d; m_imm = 0; m_pc = b.pc; m_v = 1;
        end
      end
      if (imem_rvalid) begin
        b.d = imem_rdata; b.pc = m_infl_addr;
        m_q.push_back(b);
      end
      m_infl = exp_req;
      if (exp_req) begin
        m_infl_addr = m_fpc;
        m_fpc = m_fpc + 8'd1;
      end
    end
    cyc_n++;
  endtask

  task automatic fill_one_byte();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      do v = 8'($urandom); while (two_byte(v));
      mem[i] = v;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 8'h00, 1);
    log_q.delete();
    first_valid = -1;
  endtask

  initial begin
    int r;
    int nreq;
    int li;
    int hits;
    bit done;
    bit hon;
    int hc;

    // Straight-line one-byte stream and reset values.
    fill_one_byte();
    mem[0] = 8'h34; mem[1] = 8'h40; mem[2] = 8'h00;
    do_reset(2);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_imm", imm, 0);
    chk("rst_pc", inst_pc, 0);
    r = cyc_n;
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h00, 1);
    chk("lat1", first_valid, r + 3);
    chk_issue("line0", 0, 8'h34, 8'h00, 8'h00);
    chk_issue("line1", 1, 8'h40, 8'h00, 8'h01);
    chk_issue("line2", 2, 8'h00, 8'h00, 8'h02);
    if (log_q.size() >= 3) begin
      chk("line_gap1", log_q[1].cyc - log_q[0].cyc, 1);
      chk("line_gap2", log_q[2].cyc - log_q[1].cyc, 1);
    end

    // Immediate instruction.
    mem[0] = 8'h24; mem[1] = 8'hA5; mem[2] = 8'h34;
    do_reset(2);
    r = cyc_n;
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h00, 1);
    chk("lat2", first_valid, r + 4);
    chk_issue("imm0", 0, 8'h24, 8'hA5, 8'h00);
    chk_issue("imm1", 1, 8'h34, 8'h00, 8'h02);

    // Backpressure.
    fill_one_byte();
    do_reset(2);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 8'h00, 0);
      nreq += int'(pend);
    end
    chk("bp_reqs", nreq, 5);
    chk("bp_valid", inst_valid, 1);
    chk("bp_pc", inst_pc, 0);
    chk("bp_op", inst, mem[0]);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++)
      chk_issue("bp_seq", i, mem[i], 8'h00, 8'(i));

    // Redirect while the address-5 response is in flight.
    fill_one_byte();
    do_reset(2);
    done = 0;
    li = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_infl && m_infl_addr == 8'h05) begin
        cyc(0, 0, 1, 8'h80, 1);
        done = 1;
        li = log_q.size();
      end else begin
        cyc(0, 0, 0, 8'h00, 1);
      end
    end
    chk("redir_window", done, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 8'h00, 1);
    hits = 0;
    foreach (log_q[i]) if (log_q[i].pc == 8'h05) hits++;
    chk("redir_drop5", hits, 0);
    chk_issue("redir_next", li, mem[8'h80], 8'h00, 8'h80);

    // PC wrap with halt splitting a two-byte instruction.
    fill_one_byte();
    mem[8'hFE] = 8'h34; mem[8'hFF] = 8'hB3;
    mem[8'h00] = 8'h0F; mem[8'h01] = 8'h40;
    do_reset(2);
    cyc(0, 0, 1, 8'hFE, 1);
    hon = 0;
    hc = 0;
    for (int i = 0; i < 20 && hc < 6; i++) begin
      cyc(0, hon, 0, 8'h00, 1);
      if (hon) begin
        hc++;
        chk("halt_req", pend, 0);
      end
      if (pend && pend_addr == 8'hFF) hon = 1;
    end
    chk("halt_cycles", hc, 6);
    hits = 0;
    foreach (log_q[i]) if (log_q[i].pc == 8'hFF) hits++;
    chk("halt_imm_wait", hits, 0);
    chk_issue("wrap0", 0, 8'h34, 8'h00, 8'hFE);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h00, 1);
    chk_issue("wrap1", 1, 8'hB3, 8'h0F, 8'hFF);
    chk_issue("wrap2", 2, 8'h40, 8'h00, 8'h01);

    // Mid-stream reset with an opcode held and the FIFO filled.
    for (int i = 0; i < 256; i++) mem[i] = 8'h24;
    do_reset(2);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h00, 0);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (m_hold && m_q.size() >= 3) begin
        cyc(1, 0, 0, 8'h00, 1);
        done = 1;
      end else begin
        cyc(0, 0, 0, 8'h00, 1);
      end
    end
    chk("mrst_window", done, 1);
    cyc(0, 0, 0, 8'h00, 1);
    chk("mrst_valid", inst_valid, 0);
    chk("mrst_inst", inst, 0);
    chk("mrst_imm", imm, 0);
    chk("mrst_pc", inst_pc, 0);
    chk("mrst_req", imem_req, 1);
    chk("mrst_addr", imem_addr, 0);

    // Random traffic over a random program.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(199) == 0,
          $urandom_range(9) == 0,
          $urandom_range(39) == 0,
          8'($urandom),
          $urandom_range(9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
